// File: rtl/goc_tx_arbiter.sv
// goc_tx_arbiter: two-requester arbiter in front of a single PWM transmitter.
// A requester with a complete frame is granted the transmitter. The arbiter
// holds the grant until the transmitter reports the last bit or the transmit
// watchdog expires. After release it enforces a programmable idle gap.
// Round-robin fairness is kept by a one-bit pointer that moves to the
// requester that did not own the last frame.
//
// Handshake semantics (transmitter side): tx_empty/tx_din describe the granted
// requester's character FIFO head. A character is consumed in every cycle
// where tx_re is high and a requester is granted. rq_re[i] is that same
// strobe steered to requester i. With no grant, tx_empty is forced high,
// tx_din is zero, and tx_re has no effect.
module goc_tx_arbiter #(
  parameter int WDOG_W = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  rq_frame_req,
  input  logic [8:0]  rq_data0,
  input  logic [8:0]  rq_data1,
  input  logic [1:0]  rq_empty,
  output logic [1:0]  rq_re,
  output logic [8:0]  tx_din,
  input  logic        tx_re,
  output logic        tx_empty,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic [15:0] gap_cycles,
  output logic [1:0]  grant,
  output logic [1:0]  frame_done,
  output logic [1:0]  frame_abort,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // The watchdog counts XFER cycles starting at 0. Timing out when it sits at
  // 2^WDOG_W-2 means the frame has used 2^WDOG_W-1 XFER cycles.
  localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
  localparam logic [WDOG_W-1:0] WDOG_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};
  localparam logic [WDOG_W-1:0] WDOG_ZERO = '0;

  state_t            state;
  state_t            state_next;
  logic [1:0]        grant_next;
  logic              rr;
  logic              rr_next;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_next;
  logic [15:0]       gap_cnt;
  logic [15:0]       gap_next;
  logic [1:0]        done_next;
  logic [1:0]        abort_next;
  logic [1:0]        pick;
  logic              timeout;
  logic              finish;

  // Register all FSM state and the registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= 2'b00;
      rr          <= 1'b0;
      wdog        <= WDOG_ZERO;
      gap_cnt     <= 16'd0;
      frame_done  <= 2'b00;
      frame_abort <= 2'b00;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      rr          <= rr_next;
      wdog        <= wdog_next;
      gap_cnt     <= gap_next;
      frame_done  <= done_next;
      frame_abort <= abort_next;
    end
  end

  // Choose a winner among pending requesters; rr breaks ties.
  always_comb begin
    pick = 2'b00;
    case (rq_frame_req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = rr ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

  // Next-state logic: the frame ends on tx_done, otherwise on the watchdog.
  always_comb begin
    state_next = state;
    grant_next = grant;
    rr_next    = rr;
    wdog_next  = wdog;
    gap_next   = gap_cnt;
    done_next  = 2'b00;
    abort_next = 2'b00;
    timeout    = (state == S_XFER) && (wdog == WDOG_LAST);
    finish     = (state == S_XFER) && (tx_done || timeout);

    case (state)
      S_IDLE: begin
        if (rq_frame_req != 2'b00) begin
          grant_next = pick;
          state_next = S_START;
        end
      end
      S_START: begin
        wdog_next  = WDOG_ZERO;
        state_next = S_XFER;
      end
      S_XFER: begin
        wdog_next = wdog + WDOG_ONE;
        if (finish) begin
          // A timeout that coincides with tx_done is treated as a success.
          if (tx_done) begin
            done_next = grant;
          end else begin
            abort_next = grant;
          end
          grant_next = 2'b00;
          rr_next    = grant[0];
          wdog_next  = WDOG_ZERO;
          if (gap_cycles == 16'd0) begin
            state_next = S_IDLE;
            gap_next   = 16'd0;
          end else begin
            state_next = S_GAP;
            gap_next   = gap_cycles;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt <= 16'd1) begin
          gap_next   = 16'd0;
          state_next = S_IDLE;
        end else begin
          gap_next = gap_cnt - 16'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

  // Steer the transmitter datapath from the current grant.
  always_comb begin
    tx_din   = 9'd0;
    tx_empty = 1'b1;
    rq_re    = 2'b00;
    if (grant[0]) begin
      tx_din   = rq_data0;
      tx_empty = rq_empty[0];
      rq_re    = {1'b0, tx_re};
    end else if (grant[1]) begin
      tx_din   = rq_data1;
      tx_empty = rq_empty[1];
      rq_re    = {tx_re, 1'b0};
    end
  end

  assign tx_start  = (state == S_START);
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule
